pwl_run_ctrl: RTL and testbench

- Run sequencer in front of pwl_generator: takes host commands (run forever, run N batches, stop) and turns them into the generator's run/halt handshake.
- Optionally waits for an external trigger, counts emitted batches and completed wave periods, enforces a start timeout and reports status.
- Sits between the AXI-lite command register bank and pwl_generator, in the same clock domain.

---
 rtl/pwl_run_ctrl_pkg.sv | 11 +
 rtl/pwl_run_ctrl_edge_detect.sv | 22 ++
 rtl/pwl_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pwl_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwl_run_ctrl_pkg.sv
// Shared types for the pwl_generator run sequencer.
package pwl_ctrl_pkg;

    typedef enum logic [1:0] {NOP, RUN_FOREVER, RUN_N, STOP} pwl_cmd_t;

    typedef enum logic [2:0] {IDLE, ARM, START, RUNNING, STOPPING} ctrl_state_t;

    // Upper bound on generator pipeline overshoot plus halt acknowledge time.
    localparam int HALT_LAT_MAX = 8;

endpackage

// File: rtl/pwl_run_ctrl_edge_detect.sv
// Single-bit registered rising-edge detector (used on ext_trig).
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Delay the input one cycle and flag a 0->1 transition as a registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/pwl_run_ctrl.sv
// Run sequencer for pwl_generator: turns host run/stop commands into the
// generator's run pulse / halt level, counts batches and wave periods,
// guards the start with a timeout and reports busy/done/error.
module pwl_run_ctrl
    import pwl_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH   = 32,
    parameter int PERIOD_WIDTH  = 32,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [COUNT_WIDTH-1:0]  cmd_count,
    input  logic                    trig_en,
    input  logic                    ext_trig,
    input  logic                    gen_rdy_to_run,
    input  logic                    gen_valid_batch,
    input  logic [PERIOD_WIDTH-1:0] gen_period,
    output logic                    gen_run,
    output logic                    gen_halt,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [COUNT_WIDTH-1:0]  batches_sent,
    output logic [PERIOD_WIDTH-1:0] periods_done
);

    localparam int TW = $clog2(START_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

    ctrl_state_t state, state_nxt;
    pwl_cmd_t    op;

    logic                    trig_rise;
    logic                    run_n, run_n_nxt;
    logic [COUNT_WIDTH-1:0]  cnt_lim, lim_nxt;
    logic [COUNT_WIDTH-1:0]  bs_inc, bs_nxt;
    logic [PERIOD_WIDTH-1:0] per_cnt, pc_nxt, pd_nxt;
    logic [TW-1:0]           to_cnt;
    logic                    err_nxt, done_nxt;
    logic                    cmd_acc, is_run, is_stop, reach;

    assign op      = pwl_cmd_t'(cmd_op);
    assign cmd_acc = cmd_valid && cmd_ready;
    assign is_run  = cmd_acc && (op == RUN_FOREVER || op == RUN_N);
    assign is_stop = cmd_acc && (op == STOP);
    assign bs_inc  = (batches_sent == '1) ? batches_sent : batches_sent + 1'b1;
    assign reach   = run_n && gen_valid_batch && (bs_inc == cnt_lim);

    edge_detect u_trig (
        .clk  (clk),
        .rst  (rst),
        .d    (ext_trig),
        .rise (trig_rise)
    );

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        state_nxt = state;
        run_n_nxt = run_n;
        lim_nxt   = cnt_lim;
        bs_nxt    = batches_sent;
        pc_nxt    = per_cnt;
        pd_nxt    = periods_done;
        err_nxt   = error;
        done_nxt  = 1'b0;

        // Every batch seen after the run pulse is counted, including
        // pipeline overshoot while halting.
        if ((state == START || state == RUNNING || state == STOPPING) && gen_valid_batch) begin
            bs_nxt = bs_inc;
            if (gen_period != '0) begin
                // >= rather than == so a shrinking period still wraps cleanly.
                if (per_cnt >= gen_period - PERIOD_WIDTH'(1)) begin
                    pc_nxt = '0;
                    pd_nxt = (periods_done == '1) ? periods_done : periods_done + 1'b1;
                end else begin
                    pc_nxt = per_cnt + 1'b1;
                end
            end
        end

        case (state)
            IDLE: begin
                if (is_run) begin
                    if (op == RUN_N && cmd_count == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        run_n_nxt = (op == RUN_N);
                        lim_nxt   = cmd_count;
                        bs_nxt    = '0;
                        pc_nxt    = '0;
                        pd_nxt    = '0;
                        err_nxt   = 1'b0;
                        state_nxt = trig_en ? ARM : START;
                    end
                end
            end
            ARM: begin
                if (is_run) err_nxt = 1'b1;
                if (is_stop)        state_nxt = IDLE;
                else if (trig_rise) state_nxt = START;
            end
            START: begin
                if (is_run) err_nxt = 1'b1;
                if (is_stop) begin
                    state_nxt = STOPPING;
                end else if (gen_valid_batch) begin
                    state_nxt = reach ? STOPPING : RUNNING;
                end else if (to_cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = STOPPING;
                end
            end
            RUNNING: begin
                if (is_run) err_nxt = 1'b1;
                if (is_stop || reach) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (gen_rdy_to_run) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            run_n        <= 1'b0;
            cnt_lim      <= '0;
            per_cnt      <= '0;
            to_cnt       <= '0;
            cmd_ready    <= 1'b0;
            gen_run      <= 1'b0;
            gen_halt     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            batches_sent <= '0;
            periods_done <= '0;
        end else begin
            state        <= state_nxt;
            run_n        <= run_n_nxt;
            cnt_lim      <= lim_nxt;
            per_cnt      <= pc_nxt;
            // Timeout counter is 0 on the first START cycle (same cycle as gen_run).
            to_cnt       <= (state == START) ? to_cnt + 1'b1 : '0;
            gen_run      <= (state_nxt == START) && (state != START);
            gen_halt     <= (state_nxt == STOPPING);
            busy         <= (state_nxt != IDLE);
            done         <= done_nxt;
            error        <= err_nxt;
            batches_sent <= bs_nxt;
            periods_done <= pd_nxt;
            case (state_nxt)
                IDLE:     cmd_ready <= gen_rdy_to_run;
                STOPPING: cmd_ready <= 1'b0;
                default:  cmd_ready <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_pwl_run_ctrl.sv
// Directed bench for pwl_run_ctrl with a small behavioural generator model.
module tb_pwl_run_ctrl;
    import pwl_ctrl_pkg::*;

    localparam int ACK_DLY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_count = '0;
    logic        trig_en = 1'b0;
    logic        ext_trig = 1'b0;
    logic        gen_rdy_to_run = 1'b1;
    logic        gen_valid_batch = 1'b0;
    logic [31:0] gen_period = '0;
    logic        gen_run, gen_halt, busy, done, error;
    logic [31:0] batches_sent, periods_done;

    pwl_run_ctrl #(.COUNT_WIDTH(32), .PERIOD_WIDTH(32), .START_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .trig_en(trig_en), .ext_trig(ext_trig),
        .gen_rdy_to_run(gen_rdy_to_run), .gen_valid_batch(gen_valid_batch),
        .gen_period(gen_period), .gen_run(gen_run), .gen_halt(gen_halt), .busy(busy),
        .done(done), .error(error), .batches_sent(batches_sent), .periods_done(periods_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int tcnt = 0, n_run = 0, n_done = 0, n_halt = 0, n_ovl = 0, n_hbad = 0;
    int n_valid = 0, v5_t = -1, hr_t = -1, gm_left = 0;
    int g_drain = 0, g_ack = 0;
    logic g_run = 1'b0, prev_halt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic clr_trk();
        n_run = 0; n_done = 0; n_halt = 0; n_valid = 0; v5_t = -1; hr_t = -1;
    endtask

    // One clock; observe DUT just after the edge, then update the generator model.
    task automatic tick();
        @(posedge clk); #1;
        tcnt++;
        if (gen_run) n_run++;
        if (done) n_done++;
        if (gen_halt) n_halt++;
        if (gen_run && gen_halt) n_ovl++;
        if (prev_halt && !gen_halt && !done) n_hbad++;
        if (gen_halt && !prev_halt) hr_t = tcnt;
        prev_halt = gen_halt;
        if (rst) begin
            g_run = 1'b0; g_drain = 0; g_ack = 0;
            gen_valid_batch = 1'b0; gen_rdy_to_run = 1'b1;
        end else begin
            if (gen_run) g_run = 1'b1;
            if (gen_halt && g_run) begin g_run = 1'b0; g_drain = 2; g_ack = ACK_DLY; end
            gen_valid_batch = 1'b0;
            if (g_run && gm_left > 0) begin gen_valid_batch = 1'b1; gm_left--; end
            else if (g_drain > 0) begin gen_valid_batch = 1'b1; g_drain--; end
            if (gen_valid_batch) begin n_valid++; if (n_valid == 5) v5_t = tcnt; end
            if (g_run || g_drain > 0) gen_rdy_to_run = 1'b0;
            else if (g_ack > 0) begin g_ack--; gen_rdy_to_run = 1'b0; end
            else gen_rdy_to_run = 1'b1;
        end
    endtask

    task automatic issue(input pwl_cmd_t op, input logic [31:0] cnt);
        int t = 0;
        while (!cmd_ready && t < 50) begin tick(); t++; end
        if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        tick();
        cmd_valid = 1'b0; cmd_op = NOP; cmd_count = '0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (n_done == 0 && t < 60) begin tick(); t++; end
        chk(tag, n_done, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_gen_run", gen_run, 0);
        chk("rst_gen_halt", gen_halt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_batches", batches_sent, 0);
        chk("rst_periods", periods_done, 0);
        rst = 1'b0;
        tick();

        // T1: RUN_N 5, batch every cycle, period unmeasured
        clr_trk(); gm_left = 100; gen_period = '0;
        issue(RUN_N, 5);
        chk("t1_run_pulse", gen_run, 1);
        wait_done("t1_done");
        chk("t1_run_once", n_run, 1);
        chk("t1_halt_after_5th", hr_t, v5_t + 1);
        chk("t1_batches", batches_sent, 7);
        chk("t1_overshoot_le3", (batches_sent >= 5) && (batches_sent <= 8), 1);
        chk("t1_halt_cycles", n_halt, ACK_DLY + 2);
        chk("t1_halt_lat_bound", n_halt <= HALT_LAT_MAX, 1);
        chk("t1_periods", periods_done, 0);
        chk("t1_busy_idle", busy, 0);
        tick();
        chk("t1_done_one_cycle", done, 0);

        // RUN_N with count 0 is rejected
        issue(RUN_N, 0);
        chk("cnt0_error", error, 1);
        chk("cnt0_busy", busy, 0);

        // T2: RUN_FOREVER, period 4, 12 batches, RUN while running, then STOP
        clr_trk(); gm_left = 12; gen_period = 32'd4;
        issue(RUN_FOREVER, 0);
        chk("t2_err_clr", error, 0);
        repeat (16) tick();
        chk("t2_batches", batches_sent, 12);
        chk("t2_periods", periods_done, 3);
        issue(RUN_FOREVER, 0);
        chk("t2_run_in_run_err", error, 1);
        chk("t2_run_in_run_busy", busy, 1);
        chk("t2_no_rerun", n_run, 1);
        clr_trk();
        issue(STOP, 0);
        chk("t2_halt_on_stop", gen_halt, 1);
        wait_done("t2_done");
        chk("t2_halt_held", n_halt, ACK_DLY + 2);
        chk("t2_batches_end", batches_sent, 14);
        chk("t2_periods_end", periods_done, 3);

        // T3: trigger-armed start
        clr_trk(); gm_left = 0; trig_en = 1'b1;
        issue(RUN_FOREVER, 0);
        chk("t3_err_clr", error, 0);
        repeat (100) tick();
        chk("t3_no_run_armed", n_run, 0);
        chk("t3_busy_armed", busy, 1);
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        chk("t3_run_not_yet", gen_run, 0);
        tick();
        chk("t3_run_after_trig", gen_run, 1);
        issue(STOP, 0);
        wait_done("t3_done");

        // STOP while armed: straight back to idle, no halt, no done
        clr_trk();
        issue(RUN_N, 3);
        repeat (2) tick();
        issue(STOP, 0);
        chk("arm_stop_busy", busy, 0);
        repeat (5) tick();
        chk("arm_stop_no_halt", n_halt, 0);
        chk("arm_stop_no_done", n_done, 0);
        chk("arm_stop_no_run", n_run, 0);
        trig_en = 1'b0;

        // T4: start timeout (16 cycles, no batches)
        clr_trk(); gm_left = 0;
        issue(RUN_FOREVER, 0);
        chk("t4_run_pulse", gen_run, 1);
        repeat (15) tick();
        chk("t4_err_early", error, 0);
        chk("t4_halt_early", gen_halt, 0);
        tick();
        chk("t4_err_timeout", error, 1);
        chk("t4_halt", gen_halt, 1);
        wait_done("t4_done");
        chk("t4_err_sticky", error, 1);

        // T5: reset mid-run at 7 batches, then a normal RUN_N 2
        clr_trk(); gm_left = 100; gen_period = 32'd3;
        issue(RUN_N, 20);
        begin
            int t = 0;
            while (batches_sent != 7 && t < 40) begin tick(); t++; end
        end
        chk("t5_reach7", batches_sent, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_gen_run", gen_run, 0);
        chk("t5_rst_gen_halt", gen_halt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_error", error, 0);
        chk("t5_rst_batches", batches_sent, 0);
        chk("t5_rst_periods", periods_done, 0);
        clr_trk(); gm_left = 100;
        issue(RUN_N, 2);
        wait_done("t5_done");
        chk("t5_run_once", n_run, 1);
        chk("t5_batches", batches_sent, 4);
        chk("t5_periods", periods_done, 1);

        chk("run_halt_overlap", n_ovl, 0);
        chk("halt_drop_early", n_hbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
